// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - load/status and display-bus signals of the seven-segment scan controller
interface seg_scan_ctrl_if;
  logic [31:0] digits_in;
  logic [7:0]  dp_in;
  logic [7:0]  en_in;
  logic        load;
  logic        pending;
  logic        frame_done;
  logic [7:0]  seg_out0;
  logic [7:0]  seg_out1;
  logic [7:0]  dig_sel;

  modport master (
    output digits_in, dp_in, en_in, load,
    input  pending, frame_done, seg_out0, seg_out1, dig_sel
  );

  modport slave (
    input  digits_in, dp_in, en_in, load,
    output pending, frame_done, seg_out0, seg_out1, dig_sel
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - double-buffered eight-digit seven-segment scan controller, two groups scanned in parallel
// Define SEG_SCAN_LZB_EN for leading-zero blanking.
module seg_scan_ctrl #(
  parameter int DIV   = 100000,
  parameter int BLANK = 1000
) (
  input  logic          clk,
  input  logic          rst,
  seg_scan_ctrl_if.slave bus
);
  localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [31:0]   pdig_q, pdig_d, ddig_q, ddig_d;
  logic [7:0]    pdp_q, pdp_d, pen_q, pen_d;
  logic [7:0]    ddp_q, ddp_d, den_q, den_d;
  logic          pending_q, pending_d;
  logic          frame_done_q, frame_done_d;
  logic [7:0]    dig_sel_q, dig_sel_d;
  logic [7:0]    seg0_q, seg0_d, seg1_q, seg1_d;
  logic [7:0]    lzb;
  logic          slot_end, boundary;
  logic [2:0]    lo_k, hi_k;

  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'd0:    s = 8'hFC;
      4'd1:    s = 8'h60;
      4'd2:    s = 8'hDA;
      4'd3:    s = 8'hF2;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'hB6;
      4'd6:    s = 8'hBE;
      4'd7:    s = 8'hE0;
      4'd8:    s = 8'hFE;
      4'd9:    s = 8'hF6;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] digit_seg(input logic [3:0] nib, input logic en,
                                           input logic dp, input logic blank);
    logic [7:0] s;
    s    = blank ? 8'h00 : seg_decode(nib);
    s[0] = dp;
    return en ? s : 8'h00;
  endfunction

  // Blank mask only depends on the display buffer, which changes solely at transfer.
  always_comb begin
    lzb = '0;
`ifdef SEG_SCAN_LZB_EN
    begin : lzb_scan
      logic run;
      run = 1'b1;
      for (int k = 7; k >= 1; k--) begin
        if (den_q[k]) begin
          if (ddig_q[4*k +: 4] == 4'd0) lzb[k] = run;
          else                          run    = 1'b0;
        end
      end
    end
`else
    lzb = 8'h00;
`endif
  end

  always_comb begin
    slot_end = (cnt_q == CNT_MAX);
    boundary = slot_end && (idx_q == 2'd3);
    cnt_d    = slot_end ? '0 : cnt_q + CW'(1);
    idx_d    = slot_end ? idx_q + 2'd1 : idx_q;
    lo_k     = {1'b0, idx_q};
    hi_k     = {1'b1, idx_q};

    pdig_d    = pdig_q;
    pdp_d     = pdp_q;
    pen_d     = pen_q;
    ddig_d    = ddig_q;
    ddp_d     = ddp_q;
    den_d     = den_q;
    pending_d = pending_q;
    // Transfer uses the old pending contents; a load in the same cycle waits a frame.
    if (boundary && pending_q) begin
      ddig_d    = pdig_q;
      ddp_d     = pdp_q;
      den_d     = pen_q;
      pending_d = 1'b0;
    end
    if (bus.load) begin
      pdig_d    = bus.digits_in;
      pdp_d     = bus.dp_in;
      pen_d     = bus.en_in;
      pending_d = 1'b1;
    end

    frame_done_d = boundary;
    dig_sel_d    = '0;
    if (cnt_q >= BLANK_C) begin
      dig_sel_d[lo_k] = den_q[lo_k];
      dig_sel_d[hi_k] = den_q[hi_k];
    end
    seg0_d = digit_seg(ddig_q[{lo_k, 2'b00} +: 4], den_q[lo_k], ddp_q[lo_k], lzb[lo_k]);
    seg1_d = digit_seg(ddig_q[{hi_k, 2'b00} +: 4], den_q[hi_k], ddp_q[hi_k], lzb[hi_k]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pdig_q       <= '0;
      pdp_q        <= '0;
      pen_q        <= '0;
      ddig_q       <= '0;
      ddp_q        <= '0;
      den_q        <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      dig_sel_q    <= '0;
      seg0_q       <= '0;
      seg1_q       <= '0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pdig_q       <= pdig_d;
      pdp_q        <= pdp_d;
      pen_q        <= pen_d;
      ddig_q       <= ddig_d;
      ddp_q        <= ddp_d;
      den_q        <= den_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      dig_sel_q    <= dig_sel_d;
      seg0_q       <= seg0_d;
      seg1_q       <= seg1_d;
    end
  end

  assign bus.pending    = pending_q;
  assign bus.frame_done = frame_done_q;
  assign bus.dig_sel    = dig_sel_q;
  assign bus.seg_out0   = seg0_q;
  assign bus.seg_out1   = seg1_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed and randomized checks of seg_scan_ctrl against a time-indexed reference model
module tb_seg_scan_ctrl;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * DIV;
  localparam logic [7:0] SEG_TBL [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                          8'hFE, 8'hF6, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef SEG_SCAN_LZB_EN
  localparam logic [7:0] LZ = 8'h00;
`else
  localparam logic [7:0] LZ = 8'hFC;
`endif

  logic clk;
  logic rst;
  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          n;
  logic [31:0] pd_d, ds_d;
  logic [7:0]  pd_p, pd_e, ds_p, ds_e;
  logic        m_pend;
  logic [7:0]  e_sel, e_s0, e_s1;
  logic        e_fd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at n=%0d", tag, obs, exp, n);
    end
  endtask

  task automatic m_reset();
    n = 0;
    pd_d = '0; pd_p = '0; pd_e = '0;
    ds_d = '0; ds_p = '0; ds_e = '0;
    m_pend = 1'b0;
  endtask

  function automatic logic [7:0] ref_seg(input int k);
    logic [3:0] nib;
    logic [7:0] s;
    nib = ds_d[4*k +: 4];
    if (!ds_e[k]) return 8'h00;
    s = SEG_TBL[nib];
`ifdef SEG_SCAN_LZB_EN
    if (k >= 1 && nib == 4'd0) begin
      bit lead;
      lead = 1'b1;
      for (int j = k + 1; j < 8; j++)
        if (ds_e[j] && ds_d[4*j +: 4] != 4'd0) lead = 1'b0;
      if (lead) s = 8'h00;
    end
`endif
    s[0] = ds_p[k];
    return s;
  endfunction

  // n counts clock edges since reset release; slot and scan position follow from it.
  task automatic model_step(input logic ld, input logic [31:0] d, input logic [7:0] p, input logic [7:0] e);
    int c, i;
    c = n % DIV;
    i = (n / DIV) % 4;
    e_sel = 8'h00;
    if (c >= BLANK) begin
      e_sel[i]     = ds_e[i];
      e_sel[i + 4] = ds_e[i + 4];
    end
    e_s0 = ref_seg(i);
    e_s1 = ref_seg(i + 4);
    e_fd = (n % FRAME) == FRAME - 1;
    if (e_fd && m_pend) begin
      ds_d = pd_d; ds_p = pd_p; ds_e = pd_e;
      m_pend = 1'b0;
    end
    if (ld) begin
      pd_d = d; pd_p = p; pd_e = e;
      m_pend = 1'b1;
    end
    n++;
  endtask

  task automatic cyc(input logic ld, input logic [31:0] d, input logic [7:0] p, input logic [7:0] e);
    bus.load      = ld;
    bus.digits_in = d;
    bus.dp_in     = p;
    bus.en_in     = e;
    @(posedge clk);
    model_step(ld, d, p, e);
    #1;
    chk("dig_sel",    {24'h0, bus.dig_sel},  {24'h0, e_sel});
    chk("seg_out0",   {24'h0, bus.seg_out0}, {24'h0, e_s0});
    chk("seg_out1",   {24'h0, bus.seg_out1}, {24'h0, e_s1});
    chk("pending",    {31'h0, bus.pending},  {31'h0, m_pend});
    chk("frame_done", {31'h0, bus.frame_done}, {31'h0, e_fd});
    bus.load = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 8'h0, 8'h0);
  endtask

  function automatic logic [31:0] rand_digits();
    logic [31:0] d;
    for (int k = 0; k < 8; k++)
      d[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    return d;
  endfunction

  initial begin
    rst = 1'b1;
    bus.load = 1'b0; bus.digits_in = '0; bus.dp_in = '0; bus.en_in = '0;
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_dig_sel", {24'h0, bus.dig_sel},  32'h0);
    chk("rst_seg0",    {24'h0, bus.seg_out0}, 32'h0);
    chk("rst_seg1",    {24'h0, bus.seg_out1}, 32'h0);
    chk("rst_pending", {31'h0, bus.pending},  32'h0);
    rst = 1'b0;

    // scan sequence
    cyc(1'b1, 32'h76543210, 8'h00, 8'hFF);
    repeat (30) idle();
    chk("scan_pend_before", {31'h0, bus.pending}, 32'h1);
    idle();
    chk("scan_fd", {31'h0, bus.frame_done}, 32'h1);
    chk("scan_pend_after", {31'h0, bus.pending}, 32'h0);
    idle();
    idle();
    chk("scan_blank", {24'h0, bus.dig_sel}, 32'h00);
    idle();
    chk("scan_sel0", {24'h0, bus.dig_sel},  32'h11);
    chk("scan_s0_0", {24'h0, bus.seg_out0}, 32'hFC);
    chk("scan_s1_0", {24'h0, bus.seg_out1}, 32'h66);
    while (n != 43) idle();
    chk("scan_sel1", {24'h0, bus.dig_sel},  32'h22);
    chk("scan_s0_1", {24'h0, bus.seg_out0}, 32'h60);
    chk("scan_s1_1", {24'h0, bus.seg_out1}, 32'hB6);

    // double buffer: latest load before the boundary wins
    while (n != 45) idle();
    cyc(1'b1, 32'h11111111, 8'h0F, 8'hFF);
    while (n != 50) idle();
    cyc(1'b1, 32'h98765432, 8'hA5, 8'h7E);
    while (n != 63) idle();
    chk("dbuf_pend", {31'h0, bus.pending}, 32'h1);
    idle();
    chk("dbuf_pend_clr", {31'h0, bus.pending}, 32'h0);

    // load on the boundary cycle itself
    while (n != 70) idle();
    cyc(1'b1, 32'h24682468, 8'h00, 8'hFF);
    while (n != 95) idle();
    cyc(1'b1, 32'h13571357, 8'hFF, 8'hFF);
    chk("coll_fd",   {31'h0, bus.frame_done}, 32'h1);
    chk("coll_pend", {31'h0, bus.pending},    32'h1);
    while (n != 127) idle();
    chk("coll_pend_hold", {31'h0, bus.pending}, 32'h1);
    idle();
    chk("coll_pend_clr", {31'h0, bus.pending}, 32'h0);

    // decode edges: A-F with dp, digit 4 disabled
    cyc(1'b1, 32'hFEDCBA10, 8'hFF, 8'hEF);
    while (n != 163) idle();
    chk("dec_sel0", {24'h0, bus.dig_sel},  32'h01);
    chk("dec_s0_0", {24'h0, bus.seg_out0}, 32'hFD);
    chk("dec_s1_0", {24'h0, bus.seg_out1}, 32'h00);
    while (n != 179) idle();
    chk("dec_sel2", {24'h0, bus.dig_sel},  32'h44);
    chk("dec_s0_2", {24'h0, bus.seg_out0}, 32'h01);
    chk("dec_s1_2", {24'h0, bus.seg_out1}, 32'h01);

    // leading zeros
    while (n != 192) idle();
    cyc(1'b1, 32'h00000305, 8'h00, 8'hFF);
    while (n != 235) idle();
    chk("lzb_d1", {24'h0, bus.seg_out0}, 32'hFC);
    chk("lzb_d5", {24'h0, bus.seg_out1}, {24'h0, LZ});
    while (n != 243) idle();
    chk("lzb_d2", {24'h0, bus.seg_out0}, 32'hF2);
    chk("lzb_d6", {24'h0, bus.seg_out1}, {24'h0, LZ});
    while (n != 256) idle();
    cyc(1'b1, 32'h00000000, 8'h00, 8'hFF);
    while (n != 291) idle();
    chk("lzb_z0", {24'h0, bus.seg_out0}, 32'hFC);
    chk("lzb_z4", {24'h0, bus.seg_out1}, {24'h0, LZ});
    while (n != 299) idle();
    chk("lzb_z1", {24'h0, bus.seg_out0}, {24'h0, LZ});

    // randomized traffic
    for (int t = 0; t < 500; t++) begin
      if ($urandom_range(0, 15) == 0)
        cyc(1'b1, rand_digits(), 8'($urandom()),
            ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom()));
      else
        idle();
    end

    // reset mid-slot with an update pending
    while (n % FRAME != 5) idle();
    cyc(1'b1, 32'h88888888, 8'hFF, 8'hFF);
    while (n % FRAME != 12) idle();
    chk("mrst_pend_pre", {31'h0, bus.pending}, 32'h1);
    rst = 1'b1;
    #1;
    chk("mrst_dig_sel", {24'h0, bus.dig_sel},    32'h0);
    chk("mrst_seg0",    {24'h0, bus.seg_out0},   32'h0);
    chk("mrst_seg1",    {24'h0, bus.seg_out1},   32'h0);
    chk("mrst_pending", {31'h0, bus.pending},    32'h0);
    chk("mrst_fd",      {31'h0, bus.frame_done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    repeat (3 * FRAME) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the EGO1 eight-digit seven-segment display, sitting between system logic and the board's two 4-digit segment buses. Accepts eight BCD digits, a decimal-point mask and a digit-enable mask via a load strobe. Double-buffers them so updates land only on frame boundaries, which prevents tearing. Decodes and scans both groups in parallel, with dead time between digits to suppress ghosting.

## Interface
- DIV, 100000: clock cycles per scan slot (≥ BLANK+2).
- BLANK, 1000: cycles at slot start with all digit selects low (dead time).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- digits_in  in  32  BCD nibbles; digit k = bits[4k+3:4k]; digit 0 is rightmost, digit 7 leftmost.
- dp_in  in  8  decimal point per digit, 1 = lit.
- en_in  in  8  digit enable mask, 1 = digit shown.
- load  in  1  single-cycle strobe; captures digits_in/dp_in/en_in into the pending buffer.
- pending  out  1  high while a captured update has not yet been applied.
- frame_done  out  1  one-cycle pulse on each frame boundary.
- seg_out0  out  8  segment bus, right group (digits 0–3); bit7 = a … bit1 = g, bit0 = dp; active-high.
- seg_out1  out  8  segment bus, left group (digits 4–7); same encoding.
- dig_sel  out  8  digit selects, active-high; bit k = digit k.

## Operation
- Registers: slot counter cnt (0..DIV-1); scan index idx (0..3); pending buffer; display buffer; pending flag.
- Slot sequencing: cnt increments every cycle. At cnt = DIV-1, cnt goes to 0 and idx advances; 3 wraps to 0.
- Slot phases:
  - BLANK phase, cnt < BLANK: dig_sel = 0.
  - SHOW phase: dig_sel[idx] = en[idx] and dig_sel[idx+4] = en[idx+4], all others 0.
- Segment buses use display-buffer digit idx (seg_out0) and idx+4 (seg_out1).
- Decode:
  - 0→FC, 1→60, 2→DA, 3→F2, 4→66, 5→B6, 6→BE, 7→E0, 8→FE, 9→F6 (hex, bit0 = 0).
  - Nibbles A–F decode to 00.
  - bit0 is then forced to dp.
  - A disabled digit drives 00 on its bus.
- Frame boundary: the cycle where cnt = DIV-1 and idx = 3.
  - frame_done pulses.
  - If pending = 1, the display buffer takes the pending buffer and pending clears.
- Load:
  - load = 1 captures the inputs into the pending buffer and sets pending.
  - A new load while pending overwrites the buffer; latest wins.
  - load on the boundary cycle itself: the previous pending contents (if any) apply. The new capture stays pending for the next frame.
- Reset: all outputs 0, cnt = 0, idx = 0, both buffers 0 (en = 0 so nothing lit), pending = 0.
  - Reset mid-frame discards pending data with no partial apply.

## Timing
- All outputs registered. dig_sel and segment buses reflect cnt/idx of the previous cycle (1-cycle latency).
- First cycle after reset deassertion: outputs remain 0; first SHOW selects appear at cycle BLANK+1.
- Frame period: 4·DIV cycles; refresh rate per digit = f_clk/(4·DIV), i.e. 250 Hz at 100 MHz with defaults.
- Update latency: load to visible change is at most 4·DIV+1 cycles.
- frame_done and the buffer transfer are coincident, one cycle after the boundary condition.
- Segment buses change only at slot starts (during BLANK), never while a digit is selected.

## Configuration
- SEG_SCAN_LZB_EN defined → leading-zero blanking.
  - An enabled digit k ≥ 1 whose nibble and all higher enabled nibbles are 0 drives segments a–g = 0.
  - dp is still honoured for such digits.
  - Digit 0 is never blanked.
  - Evaluated on the display buffer at transfer time.
- Undefined → zeros always displayed as FC.

## Test plan
- Reset: rst high mid-slot with pending = 1 → all outputs 0 and pending = 0 the same cycle; after release, dig_sel stays 0 indefinitely (en = 0).
- Scan sequence, DIV = 8, BLANK = 2: load digits 0x76543210, dp 0x00, en 0xFF; after the boundary, successive slots give:
  - dig_sel 00 (2 cycles), then 11 (6 cycles); seg_out0 = FC, seg_out1 = 66.
  - Next slot selects 22 with seg_out0 = 60, seg_out1 = B6.
  - Repeats through 44 and 88.
- Double-buffer: load A mid-frame, then load B before the boundary → only B appears after the boundary; pending drops with frame_done.
- Boundary collision: load C on the exact boundary cycle while A is pending → A applies now; C applies one frame later (pending stays high 4·DIV cycles).
- Decode edges: digit nibbles A–F with dp = 1 → bus = 01. Digit disabled via en → dig_sel bit never set and bus = 00 in its slot.
- Leading-zero blanking (SEG_SCAN_LZB_EN), digits 0x00000305, en 0xFF:
  - Digits 7–3 give 00 and digit 2 gives F2; digit 1, an interior zero, stays FC.
  - Digits 0x00000000 → only digit 0 shows FC.
  - Without the macro, all digits show their decoded value.
